// File: rtl/uart_rx_fifo_if.sv
// Purpose: bundles the uart_rx_fifo write/read/status signals into one port.
// Latency: none of its own; carries signals only.
// Backpressure: a write is dropped while full (overrun is raised) and rts_n asks the sender to pause.
//
// Signals: wr_data/wr_en (byte strobe from uart_rx), rd_en/rd_data (FWFT pop),
// empty/full/level/rts_n (status), overrun/clr_overrun (sticky drop flag).
// master = host side driving the FIFO; slave = the FIFO itself.
interface uart_rx_fifo_if #(
    parameter int DBITS     = 8,
    parameter int ADDR_BITS = 4
);
    logic [DBITS-1:0]   wr_data;
    logic               wr_en;
    logic               rd_en;
    logic [DBITS-1:0]   rd_data;
    logic               empty;
    logic               full;
    logic [ADDR_BITS:0] level;
    logic               overrun;
    logic               clr_overrun;
    logic               rts_n;

    modport master (
        output wr_data, wr_en, rd_en, clr_overrun,
        input  rd_data, empty, full, level, overrun, rts_n
    );

    modport slave (
        input  wr_data, wr_en, rd_en, clr_overrun,
        output rd_data, empty, full, level, overrun, rts_n
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: circular receive buffer behind uart_rx with FWFT read port, status and RTS flow control.
// Latency: a byte written at edge N is visible on rd_data with empty=0 right after edge N.
// Backpressure: rts_n rises at level >= AFULL_LEVEL; writes while full are dropped and set sticky overrun.
//
// Ports: clk, reset (synchronous, active-high), bus (slave modport of uart_rx_fifo_if).
module uart_rx_fifo #(
    parameter int DBITS       = 8,
    parameter int ADDR_BITS   = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int                 DEPTH    = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_L   = DEPTH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] AFULL_L  = AFULL_LEVEL[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] LVL_ONE  = 1;
    localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;

    logic [DBITS-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   level_q;
    logic [ADDR_BITS:0]   level_nxt;
    logic                 empty_q;
    logic                 full_q;
    logic                 rts_q;
    logic                 overrun_q;
    logic                 rd_acc;
    logic                 wr_acc;

    // A read frees the head slot this cycle, so a write may land even when full.
    assign rd_acc = bus.rd_en & ~empty_q;
    assign wr_acc = bus.wr_en & (~full_q | rd_acc);

    always_comb begin
        level_nxt = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level_q + LVL_ONE;
            2'b01:   level_nxt = level_q - LVL_ONE;
            default: level_nxt = level_q;
        endcase
    end

    // Flags are computed from level_nxt so they stay coherent with level.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            rts_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
            level_q <= level_nxt;
            empty_q <= (level_nxt == '0);
            full_q  <= (level_nxt == FULL_L);
            rts_q   <= (level_nxt >= AFULL_L);
            // A drop in the same cycle as a clear wins, so no drop is ever lost.
            if (bus.wr_en && !wr_acc)
                overrun_q <= 1'b1;
            else if (bus.clr_overrun)
                overrun_q <= 1'b0;
        end
    end

    // Storage has no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.wr_data;
    end

    assign bus.rd_data = mem[rd_ptr];
    assign bus.empty   = empty_q;
    assign bus.full    = full_q;
    assign bus.level   = level_q;
    assign bus.rts_n   = rts_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose: directed scoreboard bench for uart_rx_fifo.
// Latency: stimulus drives 1 time unit after posedge; the monitor samples on negedge.
// Backpressure: exercises full/drop/overrun and rts_n threshold.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic reset;

    uart_rx_fifo_if #(.DBITS(8), .ADDR_BITS(4)) bus ();

    uart_rx_fifo #(.DBITS(8), .ADDR_BITS(4), .AFULL_LEVEL(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: every cycle where a pop will be accepted, compare head against scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.rd_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: got 0x%0h, expected no data at %0t",
                         bus.rd_data, $time);
            end else begin
                chk("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en       = 1'b0;
        bus.rd_en       = 1'b0;
        bus.clr_overrun = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input bit accepted);
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        if (accepted) exp_q.push_back(d);
        cyc();
        idle();
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        cyc();
        idle();
    endtask

    task automatic push_pop(input logic [7:0] d);
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        exp_q.push_back(d);
        cyc();
        idle();
    endtask

    task automatic chk_status(input string tag, input int lvl, input int emp,
                              input int ful, input int rts, input int ovr);
        chk({tag, "_level"},   int'(bus.level),   lvl);
        chk({tag, "_empty"},   int'(bus.empty),   emp);
        chk({tag, "_full"},    int'(bus.full),    ful);
        chk({tag, "_rts_n"},   int'(bus.rts_n),   rts);
        chk({tag, "_overrun"}, int'(bus.overrun), ovr);
    endtask

    initial begin
        bus.wr_data = 8'h00;
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        chk_status("reset", 0, 1, 0, 0, 0);

        // Single byte in and out.
        push(8'hA5, 1'b1);
        chk_status("one", 1, 0, 0, 0, 0);
        chk("one_rd_data", int'(bus.rd_data), 8'hA5);
        pop();
        chk_status("one_pop", 0, 1, 0, 0, 0);

        // Fill to full, watching the rts_n threshold.
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 1'b1);
            chk("fill_rts_n", int'(bus.rts_n), (i + 1 >= 12) ? 1 : 0);
        end
        chk_status("full", 16, 0, 1, 1, 0);
        push(8'hFF, 1'b0);
        chk_status("drop", 16, 0, 1, 1, 1);
        // Clear coinciding with another drop: set wins.
        bus.clr_overrun = 1'b1;
        push(8'hFE, 1'b0);
        chk_status("drop_clr", 16, 0, 1, 1, 1);
        bus.clr_overrun = 1'b1;
        cyc();
        idle();
        chk_status("clr", 16, 0, 1, 1, 0);
        for (int i = 0; i < 16; i++) pop();
        chk_status("drained", 0, 1, 0, 0, 0);

        // Full FIFO with simultaneous write and read.
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b1);
        push_pop(8'h55);
        chk_status("full_wr_rd", 16, 0, 1, 1, 0);
        chk("full_wr_rd_head", int'(bus.rd_data), 8'h21);
        for (int i = 0; i < 16; i++) pop();
        chk_status("drained2", 0, 1, 0, 0, 0);

        // Empty FIFO: lone read does nothing; write+read accepts only the write.
        pop();
        chk_status("empty_rd", 0, 1, 0, 0, 0);
        push_pop(8'h3C);
        chk_status("empty_wr_rd", 1, 0, 0, 0, 0);
        chk("empty_wr_rd_data", int'(bus.rd_data), 8'h3C);
        pop();

        // Wrap-around: 40 bytes streamed through with overlapped write/read.
        push(8'h80, 1'b1);
        for (int i = 1; i < 40; i++) begin
            push_pop(8'h80 + 8'(i));
            vectors++;
            if (bus.level > 2 || bus.overrun) begin
                miscompares++;
                $display("FAIL wrap_level: level %0d overrun %0d, required level<=2 overrun=0",
                         bus.level, bus.overrun);
            end
        end
        pop();
        chk_status("wrap_done", 0, 1, 0, 0, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        // Reset mid-stream at level 9.
        for (int i = 0; i < 9; i++) push(8'h40 + 8'(i), 1'b1);
        chk_status("lvl9", 9, 0, 0, 0, 0);
        reset = 1'b1;
        exp_q.delete();
        cyc();
        reset = 1'b0;
        chk_status("mid_reset", 0, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
